mem_arbiter: RTL and testbench

- Shares one byte-addressed `memory` instance between the instruction-fetch port (read-only) and the data port (read/write) of the rv32i core.
- Accepts at most one transaction at a time and arbitrates round-robin between the two ports.
- Sequences the memory's single-cycle registered read and returns a response on a valid/ready handshake.
- Sits between the core's IF/MEM stages and the memory; the memory's `clk` is shared.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_D  = 1'b0,
        PORT_IF = 1'b1
    } arb_port_t;

    localparam int ARB_RSP_LATENCY = 3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin pick, one-hot grant
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // On a tie the requester that did not win last time is granted
    always_comb begin
        gnt[PORT_D]  = en && req[PORT_D]  && (!req[PORT_IF] || last_grant == PORT_IF);
        gnt[PORT_IF] = en && req[PORT_IF] && (!req[PORT_D]  || last_grant == PORT_D);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered-read memory between a fetch port and a data port.
// Optional address range/alignment check enabled by defining MEM_ARB_RANGE_CHECK_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MEM_SIZE = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_rsp_valid,
    input  logic             if_rsp_ready,
    output logic [WIDTH-1:0] if_rsp_data,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_rsp_valid,
    input  logic             d_rsp_ready,
    output logic [WIDTH-1:0] d_rsp_data,
    output logic             rsp_err,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    arb_state_t       state_q, state_d;
    arb_port_t        port_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic             we_q, err_q, ren_q, wen_q;
    logic [1:0]       gnt;
    logic             accept, req_we, req_err, rsp_ready_act;
    logic [WIDTH-1:0] req_addr, req_wdata;

    rr_arb2 u_rr (
        .req        ({if_req_valid, d_req_valid}),
        .last_grant (port_q),
        .en         (state_q == IDLE),
        .gnt        (gnt)
    );

    assign if_req_ready  = gnt[PORT_IF];
    assign d_req_ready   = gnt[PORT_D];
    assign accept        = |gnt;
    assign req_addr      = gnt[PORT_IF] ? if_addr : d_addr;
    assign req_we        = gnt[PORT_D] && d_we;
    assign req_wdata     = gnt[PORT_IF] ? '0 : d_wdata;
    assign rsp_ready_act = (port_q == PORT_IF) ? if_rsp_ready : d_rsp_ready;

`ifdef MEM_ARB_RANGE_CHECK_EN
    // A word that would overrun the memory or is misaligned is answered with an error, never issued
    assign req_err = (req_addr > WIDTH'(MEM_SIZE - WIDTH/8)) || (req_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    assign mem_ren      = ren_q;
    assign mem_wen      = wen_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign if_rsp_valid = (state_q == RESP) && (port_q == PORT_IF);
    assign d_rsp_valid  = (state_q == RESP) && (port_q == PORT_D);
    assign if_rsp_data  = rdata_q;
    assign d_rsp_data   = rdata_q;
    assign rsp_err      = err_q;

    // Next-state: one transaction walks IDLE -> ISSUE -> CAPTURE -> RESP and waits for consumption
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = rsp_ready_act ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, registered strobes (high only during ISSUE) and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= PORT_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ren_q   <= accept && !req_we && !req_err;
            wen_q   <= accept && req_we && !req_err;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                we_q    <= req_we;
                err_q   <= req_err;
                port_q  <= gnt[PORT_IF] ? PORT_IF : PORT_D;
            end
            if (state_q == CAPTURE) rdata_q <= (we_q || err_q) ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench with a byte-array memory and reference model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic        rsp_err, mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit last_if = 1'b1;

    logic [7:0] mem_b [4096];
    logic [7:0] ref_b [4096];

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .MEM_SIZE(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .rsp_err(rsp_err), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte-addressed memory with registered read; addresses wrap at 4 KiB
    always @(posedge clk) begin
        if (mem_wen)
            for (int i = 0; i < 4; i++) mem_b[12'(mem_addr[11:0] + 12'(i))] = mem_wdata[8*i +: 8];
        if (mem_ren)
            mem_rdata <= {mem_b[12'(mem_addr[11:0] + 12'd3)], mem_b[12'(mem_addr[11:0] + 12'd2)],
                          mem_b[12'(mem_addr[11:0] + 12'd1)], mem_b[mem_addr[11:0]]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_b[(int'(a[11:0]) + i) % 4096];
        return r;
    endfunction

    function automatic bit range_err(input logic [31:0] a);
`ifdef MEM_ARB_RANGE_CHECK_EN
        return (a > 32'd4092) || (a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One transaction starting in an idle cycle; checks grant, latency, strobes, data and backpressure
    task automatic txn(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                       input logic [31:0] da, input logic [31:0] dd, input int hold);
        bit p_if, we, err, got, s1;
        logic [31:0] a, ed;
        int k, rc, wc;
        if_req_valid = iv; if_addr = ia;
        d_req_valid = dv; d_we = dwe; d_addr = da; d_wdata = dd;
        #1;
        p_if = iv && (!dv || !last_if);
        chk("rdy_excl", {31'b0, if_req_ready & d_req_ready}, 32'd0);
        chk("grant", {30'b0, if_req_ready, d_req_ready}, p_if ? 32'd2 : 32'd1);
        a   = p_if ? ia : da;
        we  = !p_if && dwe;
        err = range_err(a);
        @(posedge clk); #1;
        if_req_valid = 0; d_req_valid = 0;
        if_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom;
        last_if = p_if;
        ed = (we || err) ? 32'd0 : ref_read(a);
        if (we && !err) for (int i = 0; i < 4; i++) ref_b[(int'(a[11:0]) + i) % 4096] = dd[8*i +: 8];
        k = 0; rc = 0; wc = 0; got = 0; s1 = 0;
        while (!got && k < 8) begin
            @(negedge clk);
            k++;
            rc += int'(mem_ren);
            wc += int'(mem_wen);
            if (k == 1) begin
                s1 = mem_ren | mem_wen;
                if (s1) chk("mem_addr", mem_addr, a);
                if (mem_wen) chk("mem_wdata", mem_wdata, dd);
            end
            got = p_if ? if_rsp_valid : d_rsp_valid;
        end
        chk("latency", k, 32'd3);
        chk("ren_cnt", rc, {31'b0, !we && !err});
        chk("wen_cnt", wc, {31'b0, we && !err});
        chk("strobe_at_issue", {31'b0, s1}, {31'b0, !err});
        chk("other_vld", {31'b0, p_if ? d_rsp_valid : if_rsp_valid}, 32'd0);
        chk("rsp_data", p_if ? if_rsp_data : d_rsp_data, ed);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
        repeat (hold) begin
            if_req_valid = 1'($urandom); d_req_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_vld", {31'b0, p_if ? if_rsp_valid : d_rsp_valid}, 32'd1);
            chk("hold_data", p_if ? if_rsp_data : d_rsp_data, ed);
            chk("hold_rdy", {31'b0, if_req_ready | d_req_ready}, 32'd0);
        end
        if_req_valid = 0; d_req_valid = 0;
        if_rsp_ready = p_if; d_rsp_ready = !p_if;
        @(posedge clk); #1;
        if_rsp_ready = 0; d_rsp_ready = 0;
        @(negedge clk);
        chk("vld_drop", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin mem_b[i] = 8'h00; ref_b[i] = 8'h00; end
        for (int i = 0; i < 4; i++) begin
            mem_b[16 + i] = 8'(32'hDEADBEEF >> (8*i));
            ref_b[16 + i] = 8'(32'hDEADBEEF >> (8*i));
        end
        rst_n = 0;
        if_req_valid = 0; if_addr = 0; if_rsp_ready = 0;
        d_req_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {30'b0, if_req_ready, d_req_ready}, 32'd0);
        chk("rst_vld", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rst_strobe", {30'b0, mem_ren, mem_wen}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1;
        @(negedge clk);
        txn(1, 32'h10, 0, 0, 0, 0, 0);
        txn(0, 0, 1, 1, 32'h40, 32'h12345678, 0);
        txn(0, 0, 1, 0, 32'h40, 0, 0);
        txn(0, 0, 1, 0, 32'h40, 0, 5);
        txn(0, 0, 1, 0, 32'hFFE, 0, 0);
        txn(0, 0, 1, 0, 32'h1000, 0, 1);
        txn(1, 32'h1000, 0, 0, 0, 0, 0);
        // Reset during the ISSUE cycle of a write must abort it
        d_req_valid = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
        #1 chk("rst_wr_rdy", {31'b0, d_req_ready}, 32'd1);
        @(posedge clk); #1;
        d_req_valid = 0; d_we = 0;
        chk("issue_wen", {31'b0, mem_wen}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async_wen", {31'b0, mem_wen}, 32'd0);
        chk("async_addr", mem_addr, 32'd0);
        chk("async_vld", {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        last_if = 1;
        @(negedge clk);
        txn(0, 0, 1, 0, 32'h80, 0, 0);
        for (int i = 0; i < 4; i++) txn(1, 32'h10, 1, 0, 32'h40, 0, 0);
        for (int i = 0; i < 60; i++) begin
            bit iv, dv;
            iv = 1'($urandom);
            dv = 1'($urandom) | !iv;
            txn(iv, 32'h100 + 4 * $urandom_range(0, 15), dv, 1'($urandom),
                32'h100 + 4 * $urandom_range(0, 15), $urandom, $urandom_range(0, 3));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
